systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for the systolic matrix-multiply datapath. It admits one size×size job as size load beats and drives the FIFO write enables. It then issues skewed FIFO read enables and a global MAC enable for the compute wavefront, and drains the size×size result array element by element through a val/rdy output stream using the datapath's row/column output selects. One job is in flight at a time.

## Interface
- size, 16: array dimension; must be ≥2.
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- recv_val  input  1  load beat valid; data is one x column and one w row, routed straight to the datapath.
- recv_rdy  output  1  controller accepts a load beat.
- send_val  output  1  b_s_out holds a valid result element.
- send_rdy  input  1  consumer takes the result element.
- mac_en  output  1  global PE accumulate enable.
- pe_clr  output  1  one-cycle accumulator clear; the top level ORs it into the PE reset.
- x_fifo_wen  output  1×[size]  per-row tensor FIFO write enable.
- x_fifo_ren  output  1×[size]  per-row tensor FIFO read enable.
- x_fifo_full  input  1×[size]  per-row full flag.
- w_fifo_wen  output  1×[size]  per-column weight FIFO write enable.
- w_fifo_ren  output  1×[size]  per-column weight FIFO read enable.
- w_fifo_full  input  1×[size]  per-column full flag.
- out_rsel  output  $clog2(size)  result row select.
- out_csel  output  $clog2(size)  result column select.
- busy  output  1  high in CALC and DRAIN.

## Operation
- States: LOAD, CALC, DRAIN. Reset enters LOAD.
- Datapath contract: SyncFIFO q reads 0 while empty. Zero operands make the ungated mac_en window harmless.
- LOAD:
  - recv_rdy = 1 when no x_fifo_full or w_fifo_full bit is set.
  - A beat fires when recv_val & recv_rdy. On fire, all x_fifo_wen and w_fifo_wen bits pulse high that cycle. Otherwise all are low.
  - beat_cnt counts 0..size-1. The size-th fire moves the state to CALC next cycle.
- CALC:
  - cyc counts 0..3·size-3, for 3·size-2 cycles in total.
  - mac_en = 1 on every CALC cycle.
  - x_fifo_ren[i] = 1 when i ≤ cyc ≤ i+size-1.
  - w_fifo_ren[j] = 1 when j ≤ cyc ≤ j+size-1.
  - Each FIFO therefore pops exactly size entries.
  - After the last cyc, the state moves to DRAIN.
- DRAIN:
  - send_val = 1, mac_en = 0.
  - out_rsel/out_csel walk row-major from (0,0) to (size-1,size-1).
  - On send_val & send_rdy, csel increments; when csel wraps, rsel increments.
  - The fire at (size-1,size-1) moves the state to LOAD and pulses pe_clr on the next cycle. Select counters return to 0.
- Outside their state: recv_rdy = 0 outside LOAD; send_val = 0 outside DRAIN; all ren bits and mac_en = 0 outside CALC.
- Counter widths: beat_cnt is $clog2(size)+1 bits. cyc is $clog2(3·size) bits. Comparisons are unsigned.

## Timing
- Reset values of all outputs are 0, except recv_rdy, which follows the full flags in LOAD.
- Reset clears state, counters and pe_clr asynchronously, at any time.
- A reset mid-CALC or mid-DRAIN abandons the job. Clearing the FIFO and PE contents is the datapath's own rst responsibility.
- Load path: recv_rdy is combinational from state and full flags. Write enables are combinational with the fire. There is no bubble between beats.
- CALC starts the cycle after the last load fire. The first result is visible with send_val = 1 exactly 3·size-2 cycles after CALC entry.
- Drain: one element per cycle when send_rdy is held high. With send_rdy low, out_rsel/out_csel and send_val hold stable.
- pe_clr is high for exactly the first LOAD cycle after a drain. A recv_val in that cycle is accepted, because the FIFOs are empty and independent of the PEs.
- Minimum job period is size + (3·size-2) + size² cycles.

## Structure
- Shared package systolic_pkg holds:
  - the state enum (LOAD/CALC/DRAIN, 2 bits);
  - the localparam functions for CALC length (3·size-2) and the counter widths.
- One natural sub-module, systolic_skew_gen: maps cyc to the ren vector, one instance each for x and w.
- The FSM and counters stay in systolic_ctrl.

## Test plan
All scenarios use size=4; the CALC length is 10 cycles.
- Basic job: W = identity and X rows 1..16, with the datapath stubbed or real. Required: 16 outputs in order (0,0)…(3,3), equal to X, and send_val first high 10 cycles after CALC entry.
- Read skew: count ren pulses during CALC. Required: x_fifo_ren[2] high on cyc 2–5 only, w_fifo_ren[3] on cyc 3–6, each FIFO popped exactly 4 times, mac_en high for exactly 10 cycles.
- Load backpressure: force x_fifo_full[1]=1 for 3 cycles mid-LOAD. Required: recv_rdy=0 and no wen pulse during those cycles, and exactly 4 total fires before CALC.
- Drain backpressure: send_rdy toggles 1,0,0,1… Required: selects advance only on fires, no element is skipped or duplicated, and pe_clr pulses once after (3,3).
- Reset mid-CALC: assert rst at cyc 5. Required: all outputs 0 immediately, state LOAD on release, and a following job produces correct results.
- Back-to-back jobs: assert recv_val continuously across the job boundary. Required: the first beat of job 2 is accepted during the pe_clr cycle, and job-2 results are unpolluted by job 1.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and size-derived widths/lengths for the systolic controller
package systolic_pkg;
    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;
    function automatic int calc_len(input int n);
        return 3 * n - 2;
    endfunction
    function automatic int beat_w(input int n);
        return $clog2(n) + 1;
    endfunction
    function automatic int cyc_w(input int n);
        return $clog2(3 * n);
    endfunction
endpackage

// File: rtl/systolic_skew_gen.sv
// systolic_skew_gen: lane i reads during the size-cycle window starting at cyc == i
module systolic_skew_gen #(
    parameter int size = 16,
    parameter int cw = 6
) (
    input  logic          en,
    input  logic [cw-1:0] cyc,
    output logic [size-1:0] ren
);
    for (genvar i = 0; i < size; i++) begin : g_lane
        assign ren[i] = en && (int'(cyc) >= i) && (int'(cyc) < i + size);
    end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: load / compute-wavefront / drain sequencer for one size x size job at a time
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int size = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    recv_val,
    output logic                    recv_rdy,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic                    mac_en,
    output logic                    pe_clr,
    output logic [size-1:0]         x_fifo_wen,
    output logic [size-1:0]         x_fifo_ren,
    input  logic [size-1:0]         x_fifo_full,
    output logic [size-1:0]         w_fifo_wen,
    output logic [size-1:0]         w_fifo_ren,
    input  logic [size-1:0]         w_fifo_full,
    output logic [$clog2(size)-1:0] out_rsel,
    output logic [$clog2(size)-1:0] out_csel,
    output logic                    busy
);
    localparam int bw = beat_w(size);
    localparam int cw = cyc_w(size);
    localparam int sw = $clog2(size);
    localparam logic [bw-1:0] beat_last = bw'(size - 1);
    localparam logic [cw-1:0] cyc_last = cw'(calc_len(size) - 1);
    localparam logic [sw-1:0] sel_last = sw'(size - 1);

    state_t state, state_nx;
    logic [bw-1:0] beat_cnt;
    logic [cw-1:0] cyc;
    logic load_fire, send_fire, last_beat, last_cyc, last_elem;

    assign recv_rdy   = (state == LOAD) && !(|x_fifo_full) && !(|w_fifo_full);
    assign load_fire  = recv_val && recv_rdy;
    assign x_fifo_wen = {size{load_fire}};
    assign w_fifo_wen = {size{load_fire}};
    assign mac_en     = state == CALC;
    assign send_val   = state == DRAIN;
    assign send_fire  = send_val && send_rdy;
    assign busy       = state != LOAD;
    assign last_beat  = beat_cnt == beat_last;
    assign last_cyc   = cyc == cyc_last;
    assign last_elem  = (out_rsel == sel_last) && (out_csel == sel_last);

    systolic_skew_gen #(.size(size), .cw(cw)) u_x_skew (.en(mac_en), .cyc(cyc), .ren(x_fifo_ren));
    systolic_skew_gen #(.size(size), .cw(cw)) u_w_skew (.en(mac_en), .cyc(cyc), .ren(w_fifo_ren));

    always_comb begin
        state_nx = state;
        if (load_fire && last_beat) state_nx = CALC;
        else if (mac_en && last_cyc) state_nx = DRAIN;
        else if (send_fire && last_elem) state_nx = LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            cyc      <= '0;
            out_rsel <= '0;
            out_csel <= '0;
            pe_clr   <= 1'b0;
        end else begin
            state  <= state_nx;
            pe_clr <= send_fire && last_elem;
            if (load_fire) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (mac_en) cyc <= last_cyc ? '0 : cyc + 1'b1;
            if (send_fire) begin
                out_csel <= (out_csel == sel_last) ? '0 : out_csel + 1'b1;
                if (out_csel == sel_last) out_rsel <= (out_rsel == sel_last) ? '0 : out_rsel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized and directed stimulus checked every cycle against a phase/elapsed-time model
module tb_systolic_ctrl;
    localparam int n = 4;
    logic clk = 0, rst = 1, recv_val = 0, send_rdy = 0;
    logic [n-1:0] x_full = '0, w_full = '0;
    logic recv_rdy, send_val, mac_en, pe_clr, busy;
    logic [n-1:0] x_wen, x_ren, w_wen, w_ren;
    logic [1:0] rsel, csel;

    systolic_ctrl #(.size(n)) dut (
        .clk(clk), .rst(rst), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_val(send_val), .send_rdy(send_rdy), .mac_en(mac_en), .pe_clr(pe_clr),
        .x_fifo_wen(x_wen), .x_fifo_ren(x_ren), .x_fifo_full(x_full),
        .w_fifo_wen(w_wen), .w_fifo_ren(w_ren), .w_fifo_full(w_full),
        .out_rsel(rsel), .out_csel(csel), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // model: beats accepted this job, elapsed compute cycles t (0..10), results consumed k
    int beats = 0, t = 0, k = 0, cyc_n = 0, last_fire = 0;
    int mac_cnt = 0, xr2_cnt = 0, wr3_cnt = 0, sends = 0;
    bit clr = 0, prev_sv = 0;

    always @(negedge clk) begin
        bit il, ic, id, fire, nofull;
        logic [n-1:0] ren_e;
        cyc_n++;
        if (rst) begin
            beats = 0; t = 0; k = 0; clr = 0; prev_sv = 0;
            mac_cnt = 0; xr2_cnt = 0; wr3_cnt = 0; sends = 0;
        end
        il = beats < n;
        ic = beats == n && t < 3 * n - 2;
        id = beats == n && t == 3 * n - 2;
        nofull = !(|x_full) && !(|w_full);
        fire = il && recv_val && nofull;
        for (int i = 0; i < n; i++) ren_e[i] = ic && i <= t && t <= i + n - 1;
        chk("recv_rdy", recv_rdy, il && nofull);
        chk("x_wen", x_wen, fire ? 15 : 0);
        chk("w_wen", w_wen, fire ? 15 : 0);
        chk("mac_en", mac_en, ic);
        chk("x_ren", x_ren, ren_e);
        chk("w_ren", w_ren, ren_e);
        chk("send_val", send_val, id);
        chk("rsel", rsel, id ? k / n : 0);
        chk("csel", csel, id ? k % n : 0);
        chk("busy", busy, !il);
        chk("pe_clr", pe_clr, clr);
        if (!rst) begin
            if (pe_clr && recv_val && nofull) chk("clr_cycle_accept", x_wen, 15);
            mac_cnt += int'(mac_en);
            xr2_cnt += int'(x_ren[2]);
            wr3_cnt += int'(w_ren[3]);
            if (send_val && !prev_sv) chk("first_result_latency", cyc_n - last_fire, 11);
            prev_sv = send_val;
            if (send_val && send_rdy) sends++;
            clr = 0;
            if (fire) begin
                beats++;
                if (beats == n) begin t = 0; last_fire = cyc_n; end
            end else if (ic) t++;
            else if (id && send_rdy) begin
                k++;
                if (k == n * n) begin
                    beats = 0; t = 0; k = 0; clr = 1;
                    chk("job_mac_cycles", mac_cnt, 10);
                    chk("job_x_ren2_pops", xr2_cnt, 4);
                    chk("job_w_ren3_pops", wr3_cnt, 4);
                    chk("job_results", sends, 16);
                    mac_cnt = 0; xr2_cnt = 0; wr3_cnt = 0; sends = 0;
                end
            end
        end
    end

    task automatic run(input int cycles, input int mode);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            recv_val = 1;
            send_rdy = 1;
            x_full = '0;
            w_full = '0;
            if (mode == 1 && c >= 2 && c <= 4) x_full = 4'b0010;
            if (mode == 2) send_rdy = (c % 3 == 0);
            if (mode == 3) begin
                recv_val = ($urandom % 4) != 0;
                send_rdy = $urandom % 2;
                x_full = ($urandom % 8 == 0) ? 4'($urandom) : '0;
                w_full = ($urandom % 8 == 0) ? 4'($urandom) : '0;
            end
            if (mode == 1 && c >= 2 && c <= 4) begin
                #1;
                chk("bp_recv_rdy", recv_rdy, 0);
            end
        end
    endtask

    task automatic to_idle();
        int w = 0;
        @(posedge clk);
        #1;
        recv_val = 0; send_rdy = 1; x_full = '0; w_full = '0;
        while (busy && w < 100) begin @(posedge clk); #1; w++; end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        run(34, 0);
        to_idle();
        run(40, 1);
        to_idle();
        run(4, 0);
        run(70, 2);
        to_idle();
        w = 0;
        recv_val = 1; send_rdy = 1;
        while (!mac_en && w < 50) begin @(posedge clk); #1; w++; end
        chk("calc_reached", mac_en, 1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1; recv_val = 0;
        #1;
        chk("rst_mac_en", mac_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x_ren", x_ren, 0);
        @(posedge clk);
        #1 rst = 0;
        run(40, 0);
        to_idle();
        run(90, 0);
        for (int j = 0; j < 6; j++) run(60, 3);
        to_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
